uart_tx_feeder: RTL

Byte-buffering front end for the UART transmitter. Accepts bytes from a host-side write port into a DEPTH-entry FIFO and drains them one at a time into the UART transmitter's `load`/`data_in` inputs, holding `load` until the transmitter reports `tx_busy`. It then waits for the frame to finish before launching the next byte. The transmitter runs off the slow baud clock, so `tx_busy` is resynchronised and the load hold is bounded by a timeout.

---
 rtl/uart_tx_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter through a load/busy handshake with a load timeout.
// Optional sticky overflow flag is built only when UART_TX_FEEDER_OVF_EN is defined.
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int LOAD_TIMEOUT = 10416
) (
  input  logic              clk,
  input  logic              fifo_reset,
  input  logic              tx_enable,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  input  logic              tx_busy,
  output logic              load,
  output logic [7:0]        tx_data,
  output logic              load_error,
  output logic              ovf
);

  localparam int TIMER_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [ADDR_W:0]    wr_ptr_q;
  logic [ADDR_W:0]    rd_ptr_q;
  logic [7:0]         tx_data_q;
  logic               sync1_q;
  logic               busy_s_q;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               load_error_q, load_error_d;
  logic               pop;
  logic               wr_accept;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == (ADDR_W+1)'(DEPTH));
  assign empty     = (level == '0);
  // Full is judged on the current level, so a same-edge pop never rescues a write.
  assign wr_accept = wr_en && !full;

  assign load       = (state_q == LOAD);
  assign tx_data    = tx_data_q;
  assign load_error = load_error_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    load_error_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_enable && !empty && !busy_s_q) begin
          pop     = 1'b1;
          timer_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (busy_s_q) begin
          state_d = BUSY;
        end else if (timer_q == TIMER_W'(LOAD_TIMEOUT - 1)) begin
          load_error_d = 1'b1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BUSY: begin
        if (!busy_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sync1_q      <= 1'b0;
      busy_s_q     <= 1'b0;
      state_q      <= IDLE;
      timer_q      <= '0;
      load_error_q <= 1'b0;
    end else begin
      sync1_q      <= tx_busy;
      busy_s_q     <= sync1_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      load_error_q <= load_error_d;
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept && !fifo_reset) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_reset) begin
      tx_data_q <= 8'h00;
    end else if (pop) begin
      tx_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (fifo_reset) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
